// File: rtl/fifo_axis_pkg.sv
// fifo_axis_pkg: shared types for the FIFO-to-AXI4-Stream reader.
// Holds the skid-buffer state enum, the framing constant and the entry struct.
package fifo_axis_pkg;

    localparam int AXIS_DW      = 16;
    localparam int LEN_UNFRAMED = 0;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [AXIS_DW-1:0] data;
        logic               last;
    } entry_t;

endpackage

// File: rtl/fifo_axis_reader_skid.sv
// axis_skid_buf2: two-entry register buffer; output is always entry 0.
// in_ready stays high while one slot is free or entry 0 leaves this cycle.
module axis_skid_buf2
    import fifo_axis_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  entry_t in_data,
    input  logic   in_valid,
    output logic   in_ready,
    output entry_t out_data,
    output logic   out_valid,
    input  logic   out_ready
);

    buf_state_e state_q;
    entry_t     e0_q;
    entry_t     e1_q;
    logic       xfer;
    logic       push;

    assign out_valid = (state_q != B0);
    assign out_data  = e0_q;
    assign in_ready  = (state_q != B2) || out_ready;
    assign xfer      = out_valid && out_ready;
    assign push      = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= B0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            unique case (state_q)
                B0: begin
                    if (push) begin
                        e0_q    <= in_data;
                        state_q <= B1;
                    end
                end
                B1: begin
                    if (push && xfer) begin
                        e0_q <= in_data;
                    end else if (push) begin
                        e1_q    <= in_data;
                        state_q <= B2;
                    end else if (xfer) begin
                        state_q <= B0;
                    end
                end
                B2: begin
                    if (xfer) begin
                        e0_q <= e1_q;
                        if (push) e1_q <= in_data;
                        else      state_q <= B1;
                    end
                end
                default: state_q <= B0;
            endcase
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a fifo_sync into an AXI4-Stream master with TLAST framing.
// Optional FIFO_AXIS_READER_UNDERRUN_CNT_EN adds a saturating underrun_count port.
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DW,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_rd_en,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef FIFO_AXIS_READER_UNDERRUN_CNT_EN
    , output logic [31:0]         underrun_count
`endif
);

    logic                 last_zero_q;
    logic                 head_ok;
    logic                 in_ready;
    logic                 pop;
    entry_t               in_ent;
    entry_t               out_ent;
    logic                 out_valid;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] len_cur;

    // Head word is stale the cycle after a write lands on an emptied FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) last_zero_q <= 1'b1;
        else         last_zero_q <= (fifo_count == {{ADDR_WIDTH{1'b0}}, fifo_rd_en});
    end

    assign head_ok    = !fifo_empty && !last_zero_q;
    assign pop        = head_ok && in_ready;
    assign fifo_rd_en = pop;

    always_comb begin
        in_ent      = '0;
        in_ent.data = AXIS_DW'(fifo_rd_data);
        cnt_d       = cnt_q;
        len_d       = len_q;
        len_cur     = (cnt_q == '0) ? pkt_len : len_q;
        if (pop && len_cur != LEN_WIDTH'(LEN_UNFRAMED)) begin
            len_d = len_cur;
            if (cnt_q == len_cur - 1'b1) begin
                in_ent.last = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

    axis_skid_buf2 u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_ent),
        .in_valid  (head_ok),
        .in_ready  (in_ready),
        .out_data  (out_ent),
        .out_valid (out_valid),
        .out_ready (m_axis_tready)
    );

    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = DATA_WIDTH'(out_ent.data);
    assign m_axis_tlast  = out_ent.last;

`ifdef FIFO_AXIS_READER_UNDERRUN_CNT_EN
    logic [31:0] und_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            und_q <= '0;
        end else if (m_axis_tready && !out_valid && cnt_q != '0 && und_q != '1) begin
            und_q <= und_q + 32'd1;
        end
    end

    assign underrun_count = und_q;
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb_fifo_axis_reader: random and directed scoreboard bench for fifo_axis_reader.
// A registered-read FIFO model feeds the DUT; a packet-level model predicts beats.
module tb_fifo_axis_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic [4:0]  fifo_count;
    logic        fifo_rd_en;
    logic [15:0] pkt_len;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
`ifdef FIFO_AXIS_READER_UNDERRUN_CNT_EN
    logic [31:0] underrun_count;
`endif

    always #5 clk = ~clk;

    fifo_axis_reader dut (
        .clk           (clk),
        .resetn        (resetn),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_empty    (fifo_empty),
        .fifo_count    (fifo_count),
        .fifo_rd_en    (fifo_rd_en),
        .pkt_len       (pkt_len),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
`ifdef FIFO_AXIS_READER_UNDERRUN_CNT_EN
        , .underrun_count (underrun_count)
`endif
    );

    // FIFO with a registered read port that reads old memory contents
    logic [15:0] mem [16];
    logic [3:0]  wp, rp;
    logic [4:0]  cnt;
    logic [15:0] rdq;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_ok;

    assign wr_ok        = wr_en && (cnt != 5'd16);
    assign fifo_rd_data = rdq;
    assign fifo_empty   = (cnt == 5'd0);
    assign fifo_count   = cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            rdq <= '0;
        end else begin
            rdq <= mem[rp + 4'(fifo_rd_en)];
            if (wr_ok) begin
                mem[wp] <= wr_data;
                wp      <= wp + 4'd1;
            end
            rp  <= rp + 4'(fifo_rd_en);
            cnt <= cnt + 5'(wr_ok) - 5'(fifo_rd_en);
        end
    end

    typedef struct {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t sbq[$];
    int   m_pos;
    int   m_len;
    int   vecs;
    int   errs;
    int   nbeats;
    int   occ;
    logic stall_q;
    logic [15:0] hold_d;
    logic hold_l;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Packet model: len is the pkt_len in force when this word is popped
    function automatic void sb_push(logic [15:0] w, int len);
        exp_t e;
        e.d = w;
        e.l = 1'b0;
        if (m_pos == 0) m_len = len;
        if (m_len != 0) begin
            m_pos++;
            if (m_pos == m_len) begin
                e.l   = 1'b1;
                m_pos = 0;
            end
        end
        sbq.push_back(e);
    endfunction

    initial begin
        vecs    = 0;
        errs    = 0;
        nbeats  = 0;
        occ     = 0;
        stall_q = 1'b0;
        hold_d  = '0;
        hold_l  = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                occ     = 0;
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("hold_valid", 32'(tvalid), 1);
                    chk("hold_data", {tlast, tdata}, {hold_l, hold_d});
                end
                if (tvalid && tready) begin
                    if (sbq.size() == 0) begin
                        vecs++;
                        errs++;
                        $display("FAIL unexpected_beat: got %0h want none", tdata);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("tdata", 32'(tdata), 32'(e.d));
                        chk("tlast", 32'(tlast), 32'(e.l));
                    end
                    nbeats++;
                end
                occ = occ + int'(fifo_rd_en) - int'(tvalid && tready);
                if (fifo_rd_en || (tvalid && tready))
                    chk("occupancy_le2", 32'(occ <= 2), 1);
                stall_q = tvalid && !tready;
                hold_d  = tdata;
                hold_l  = tlast;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(logic [15:0] w, int len);
        wr_en   = 1'b1;
        wr_data = w;
        sb_push(w, len);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(bit rnd);
        int k;
        k = 0;
        while ((sbq.size() != 0 || cnt != 0 || tvalid) && k < 2000) begin
            tready = rnd ? 1'($urandom) : 1'b1;
            step();
            k++;
        end
        tready = 1'b1;
        chk("drain_in_time", 32'(k < 2000), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int lens [6];
        lens    = '{0, 1, 2, 3, 5, 65535};
        m_pos   = 0;
        m_len   = 0;
        resetn  = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        pkt_len = '0;
        tready  = 1'b0;

        repeat (3) step();
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tdata", 32'(tdata), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        resetn = 1'b1;
        step();

        // preloaded burst drains back-to-back
        for (int i = 1; i <= 8; i++) wr_word(16'(i), 0);
        repeat (4) step();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("consec_valid", 32'(tvalid), 1);
            step();
        end
        wait_drain(0);

        // single write into an empty FIFO
        step();
        wr_en   = 1'b1;
        wr_data = 16'hABCD;
        sb_push(16'hABCD, 0);
        @(negedge clk);
        chk("lat_c0_rd_en", 32'(fifo_rd_en), 0);
        step();
        wr_en = 1'b0;
        @(negedge clk);
        chk("lat_c1_rd_en", 32'(fifo_rd_en), 0);
        step();
        @(negedge clk);
        chk("lat_c2_rd_en", 32'(fifo_rd_en), 1);
        chk("lat_c2_tvalid", 32'(tvalid), 0);
        step();
        @(negedge clk);
        chk("lat_c3_tvalid", 32'(tvalid), 1);
        chk("lat_c3_tdata", 32'(tdata), 32'h0000ABCD);
        wait_drain(0);

        // write coinciding with the pop of the only word
        step();
        wr_en   = 1'b1;
        wr_data = 16'h1111;
        sb_push(16'h1111, 0);
        step();
        wr_en = 1'b0;
        step();
        wr_en   = 1'b1;
        wr_data = 16'h2222;
        sb_push(16'h2222, 0);
        @(negedge clk);
        chk("coinc_c2_rd_en", 32'(fifo_rd_en), 1);
        step();
        wr_en = 1'b0;
        @(negedge clk);
        chk("coinc_c3_rd_en", 32'(fifo_rd_en), 0);
        step();
        @(negedge clk);
        chk("coinc_c4_rd_en", 32'(fifo_rd_en), 1);
        wait_drain(0);

        // pkt_len 3 then changed to 2 mid-packet
        pkt_len = 16'd3;
        tready  = 1'b0;
        for (int i = 1; i <= 7; i++) wr_word(16'h0300 + 16'(i), (i <= 3) ? 3 : 2);
        repeat (4) step();
        tready  = 1'b1;
        pkt_len = 16'd2;
        wait_drain(0);

        // random bursts, random tready
        for (int r = 0; r < 6; r++) begin
            int n;
            int sent;
            pkt_len = 16'(lens[$urandom_range(0, 5)]);
            n       = (r == 0) ? 16 : int'($urandom_range(10, 24));
            sent    = 0;
            while (sent < n) begin
                tready = 1'($urandom);
                if (($urandom % 4) != 0 && cnt < 5'd15) begin
                    wr_en   = 1'b1;
                    wr_data = 16'($urandom);
                    sb_push(wr_data, int'(pkt_len));
                    sent++;
                end else begin
                    wr_en = 1'b0;
                end
                step();
            end
            wr_en = 1'b0;
            wait_drain(1);
        end

        // asynchronous reset in the middle of a packet
        pkt_len = 16'd4;
        tready  = 1'b0;
        for (int i = 1; i <= 8; i++) wr_word(16'h0500 + 16'(i), 4);
        repeat (4) step();
        tready = 1'b1;
        step();
        step();
        #2;
        chk("pre_rst_tvalid", 32'(tvalid), 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_tvalid", 32'(tvalid), 0);
        chk("async_rst_rd_en", 32'(fifo_rd_en), 0);
        sbq.delete();
        m_pos = 0;
        m_len = 0;
        repeat (3) step();
`ifdef FIFO_AXIS_READER_UNDERRUN_CNT_EN
        chk("rst_underrun", underrun_count, 0);
`endif
        resetn = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) wr_word(16'h0600 + 16'(i), 4);
        wait_drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
